// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: MEM/WB operand forwarding, load-use hazard detection and
// multi-cycle multiply sequencing for a 5-stage RISC-V pipeline.
// Optional feature: define FWD_STALL_CNT_EN to add the StallCnt_o stall-cycle
// counter (saturating, cleared by reset only).
module fwd_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*REG_AW-1:0] ID_rs_i,
  input  logic [NUM_SRC*REG_AW-1:0] EX_rs_i,
  input  logic [REG_AW-1:0]         EX_Rd_i,
  input  logic                      EX_MemRead_i,
  input  logic                      EX_MulStart_i,
  input  logic                      MEM_RegWrite_i,
  input  logic [REG_AW-1:0]         MEM_Rd_i,
  input  logic                      WB_RegWrite_i,
  input  logic [REG_AW-1:0]         WB_Rd_i,
  output logic [NUM_SRC*2-1:0]      Forward_o,
  output logic                      Stall_o,
  output logic                      MulBusy_o,
  output logic                      MulDone_o
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]               StallCnt_o
`endif
);

  localparam int CNT_W = $clog2(MUL_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_busy;
  logic                r_done;
  logic [NUM_SRC*2-1:0] w_fwd;
  logic                w_lu;
  logic                w_stall;

  // Per-operand forwarding select; MEM result is newer, so it wins over WB.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_fwd = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (MEM_RegWrite_i && (MEM_Rd_i != '0) &&
          (MEM_Rd_i == EX_rs_i[k*REG_AW +: REG_AW])) begin
        w_fwd[2*k +: 2] = 2'b10;
      end else if (WB_RegWrite_i && (WB_Rd_i != '0) &&
                   (WB_Rd_i == EX_rs_i[k*REG_AW +: REG_AW])) begin
        w_fwd[2*k +: 2] = 2'b01;
      end
    end
  end

  // Load-use hazard: a load in EX whose destination feeds any ID source.
  always_comb begin
    w_lu = 1'b0;
    if (EX_MemRead_i && (EX_Rd_i != '0)) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (EX_Rd_i == ID_rs_i[k*REG_AW +: REG_AW]) begin
          w_lu = 1'b1;
        end
      end
    end
  end

  // Multiply sequencer next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (EX_MulStart_i) begin
          if (MUL_LAT == 2) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = CNT_W'(MUL_LAT - 2);
          end
        end
      end
      ST_BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state, counter and registered status flags.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // The start cycle stalls too, so a multiply freezes the front end MUL_LAT-1 cycles.
  assign w_stall = w_lu
                 | ((r_state == ST_IDLE) & EX_MulStart_i)
                 | (r_state == ST_BUSY);

  // Combinational outputs are forced quiet while reset is held.
  assign Forward_o = rst_i ? w_fwd : '0;
  assign Stall_o   = rst_i & w_stall;
  assign MulBusy_o = r_busy;
  assign MulDone_o = r_done;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (Stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign StallCnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: a MUL_LAT=3 and a MUL_LAT=2 instance
// share one stimulus stream; expected rows go through a scoreboard queue.
module tb_fwd_hazard_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  ID_rs_i, EX_rs_i;
  logic [4:0]  EX_Rd_i, MEM_Rd_i, WB_Rd_i;
  logic        EX_MemRead_i, EX_MulStart_i, MEM_RegWrite_i, WB_RegWrite_i;
  logic [3:0]  fwd3, fwd2;
  logic        stall3, busy3, done3, stall2, busy2, done2;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] cnt3, cnt2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(3)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .ID_rs_i(ID_rs_i), .EX_rs_i(EX_rs_i),
    .EX_Rd_i(EX_Rd_i), .EX_MemRead_i(EX_MemRead_i), .EX_MulStart_i(EX_MulStart_i),
    .MEM_RegWrite_i(MEM_RegWrite_i), .MEM_Rd_i(MEM_Rd_i),
    .WB_RegWrite_i(WB_RegWrite_i), .WB_Rd_i(WB_Rd_i),
    .Forward_o(fwd3), .Stall_o(stall3), .MulBusy_o(busy3), .MulDone_o(done3)
`ifdef FWD_STALL_CNT_EN
    , .StallCnt_o(cnt3)
`endif
  );

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .ID_rs_i(ID_rs_i), .EX_rs_i(EX_rs_i),
    .EX_Rd_i(EX_Rd_i), .EX_MemRead_i(EX_MemRead_i), .EX_MulStart_i(EX_MulStart_i),
    .MEM_RegWrite_i(MEM_RegWrite_i), .MEM_Rd_i(MEM_Rd_i),
    .WB_RegWrite_i(WB_RegWrite_i), .WB_Rd_i(WB_Rd_i),
    .Forward_o(fwd2), .Stall_o(stall2), .MulBusy_o(busy2), .MulDone_o(done2)
`ifdef FWD_STALL_CNT_EN
    , .StallCnt_o(cnt2)
`endif
  );

  // One cycle of stimulus plus the outputs both instances must show in it.
  // flags = {stall3, busy3, done3, stall2, busy2, done2}
  typedef struct {
    string      name;
    logic [9:0] id_rs;
    logic [9:0] ex_rs;
    logic [4:0] ex_rd;
    logic       mem_read;
    logic       mul_start;
    logic       mem_rw;
    logic [4:0] mem_rd;
    logic       wb_rw;
    logic [4:0] wb_rd;
    logic [3:0] fwd;
    logic [5:0] flags;
  } row_t;

  row_t sb_q[$];

  function automatic row_t mk(string n, logic [9:0] id, logic [9:0] ex, logic [4:0] exrd,
                              logic mr, logic ms, logic mrw, logic [4:0] mrd,
                              logic wrw, logic [4:0] wrd, logic [3:0] f, logic [5:0] fl);
    row_t r;
    r.name = n; r.id_rs = id; r.ex_rs = ex; r.ex_rd = exrd; r.mem_read = mr;
    r.mul_start = ms; r.mem_rw = mrw; r.mem_rd = mrd; r.wb_rw = wrw; r.wb_rd = wrd;
    r.fwd = f; r.flags = fl;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input row_t r);
    ID_rs_i = r.id_rs; EX_rs_i = r.ex_rs; EX_Rd_i = r.ex_rd;
    EX_MemRead_i = r.mem_read; EX_MulStart_i = r.mul_start;
    MEM_RegWrite_i = r.mem_rw; MEM_Rd_i = r.mem_rd;
    WB_RegWrite_i = r.wb_rw; WB_Rd_i = r.wb_rd;
    sb_q.push_back(r);
  endtask

  task automatic compare_pop();
    row_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_fwd3"},  {28'd0, fwd3}, {28'd0, e.fwd});
      check({e.name, "_fwd2"},  {28'd0, fwd2}, {28'd0, e.fwd});
      check({e.name, "_stall3"}, {31'd0, stall3}, {31'd0, e.flags[5]});
      check({e.name, "_busy3"},  {31'd0, busy3},  {31'd0, e.flags[4]});
      check({e.name, "_done3"},  {31'd0, done3},  {31'd0, e.flags[3]});
      check({e.name, "_stall2"}, {31'd0, stall2}, {31'd0, e.flags[2]});
      check({e.name, "_busy2"},  {31'd0, busy2},  {31'd0, e.flags[1]});
      check({e.name, "_done2"},  {31'd0, done2},  {31'd0, e.flags[0]});
    end
  endtask

  // Entered at a falling edge; leaves at the next falling edge.
  task automatic run_row(input row_t r);
    apply(r);
    #2;
    compare_pop();
    @(negedge clk_i);
  endtask

  row_t vec[10];
  row_t idle_r;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_r = mk("idle", 10'd0, 10'd0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b000000);

    vec[0] = mk("fwd_mem",      10'd0, {5'd0, 5'd5}, 5'd0, 0, 0, 1, 5'd5, 1, 5'd5, 4'b0010, 6'b000000);
    vec[1] = mk("fwd_wb",       10'd0, {5'd0, 5'd5}, 5'd0, 0, 0, 0, 5'd5, 1, 5'd5, 4'b0001, 6'b000000);
    vec[2] = mk("fwd_x0",       10'd0, {5'd0, 5'd0}, 5'd0, 0, 0, 1, 5'd0, 1, 5'd0, 4'b0000, 6'b000000);
    vec[3] = mk("fwd_mix",      10'd0, {5'd9, 5'd3}, 5'd0, 0, 0, 1, 5'd3, 1, 5'd9, 4'b0110, 6'b000000);
    vec[4] = mk("fwd_both_mem", 10'd0, {5'd6, 5'd6}, 5'd0, 0, 0, 1, 5'd6, 1, 5'd6, 4'b1010, 6'b000000);
    vec[5] = mk("lu_rs2",  {5'd7, 5'd1}, 10'd0, 5'd7, 1, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b100100);
    vec[6] = mk("lu_rs1",  {5'd2, 5'd7}, 10'd0, 5'd7, 1, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b100100);
    vec[7] = mk("lu_x0",   {5'd0, 5'd0}, 10'd0, 5'd0, 1, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b000000);
    vec[8] = mk("no_load", {5'd7, 5'd0}, 10'd0, 5'd7, 0, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b000000);
    vec[9] = mk("lu_miss", {5'd9, 5'd8}, 10'd0, 5'd7, 1, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b000000);

    // Reset held with inputs that would otherwise forward, stall and start.
    rst_i = 1'b0;
    ID_rs_i = {5'd0, 5'd7}; EX_rs_i = {5'd0, 5'd5}; EX_Rd_i = 5'd7;
    EX_MemRead_i = 1'b1; EX_MulStart_i = 1'b1;
    MEM_RegWrite_i = 1'b1; MEM_Rd_i = 5'd5; WB_RegWrite_i = 1'b1; WB_Rd_i = 5'd5;
    @(negedge clk_i); #2;
    check("rst_fwd3",  {28'd0, fwd3}, 32'd0);
    check("rst_fwd2",  {28'd0, fwd2}, 32'd0);
    check("rst_stall3", {31'd0, stall3}, 32'd0);
    check("rst_stall2", {31'd0, stall2}, 32'd0);
    check("rst_busy3",  {31'd0, busy3}, 32'd0);
    check("rst_done3",  {31'd0, done3}, 32'd0);
    apply(idle_r); void'(sb_q.pop_back());
    #1 rst_i = 1'b1;
    @(negedge clk_i);

    // Combinational forwarding and load-use vectors.
    for (int i = 0; i < 10; i++) run_row(vec[i]);
    run_row(idle_r);

    // Multiply held in EX for three cycles, forwarding active throughout.
    // MUL_LAT=2 instance restarts from IDLE because the start stays high.
    run_row(mk("mulA0", 10'd0, {5'd0, 5'd4}, 5'd0, 0, 1, 1, 5'd4, 0, 5'd0, 4'b0010, 6'b100100));
    run_row(mk("mulA1", 10'd0, {5'd0, 5'd4}, 5'd0, 0, 1, 1, 5'd4, 0, 5'd0, 4'b0010, 6'b110011));
    run_row(mk("mulA2", 10'd0, {5'd0, 5'd4}, 5'd0, 0, 1, 1, 5'd4, 0, 5'd0, 4'b0010, 6'b011100));
    run_row(mk("mulA3", 10'd0, 10'd0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b000011));
    run_row(mk("mulA4", 10'd0, 10'd0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b000000));

    // Load-use coinciding with the multiply: stalls are OR'd, FSM keeps going.
    run_row(mk("mulB0", 10'd0, 10'd0, 5'd0, 0, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b100100));
    run_row(mk("mulB1", {5'd0, 5'd7}, 10'd0, 5'd7, 1, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b110111));
    run_row(mk("mulB2", 10'd0, 10'd0, 5'd0, 0, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b011100));
    run_row(mk("mulB3", 10'd0, 10'd0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b000011));
    run_row(mk("mulB4", 10'd0, 10'd0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b000000));

    // Asynchronous reset in the middle of a multiply, then a clean restart.
    run_row(mk("mulR0", 10'd0, 10'd0, 5'd0, 0, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b100100));
    apply(mk("mulR1", {5'd0, 5'd7}, {5'd0, 5'd4}, 5'd7, 1, 1, 1, 5'd4, 0, 5'd0, 4'b0010, 6'b110111));
    #2; compare_pop();
    #1 rst_i = 1'b0;
    #1;
    check("arst_busy3",  {31'd0, busy3},  32'd0);
    check("arst_done3",  {31'd0, done3},  32'd0);
    check("arst_stall3", {31'd0, stall3}, 32'd0);
    check("arst_busy2",  {31'd0, busy2},  32'd0);
    check("arst_done2",  {31'd0, done2},  32'd0);
    check("arst_stall2", {31'd0, stall2}, 32'd0);
    check("arst_fwd3",   {28'd0, fwd3},   32'd0);
    @(negedge clk_i);
    apply(idle_r); void'(sb_q.pop_back());
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    run_row(mk("mulS0", 10'd0, 10'd0, 5'd0, 0, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b100100));
    run_row(mk("mulS1", 10'd0, 10'd0, 5'd0, 0, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b110011));
    run_row(mk("mulS2", 10'd0, 10'd0, 5'd0, 0, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b011100));
    run_row(mk("mulS3", 10'd0, 10'd0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b000011));
    run_row(idle_r);

`ifdef FWD_STALL_CNT_EN
    // Fresh reset, then two multiply stall cycles plus one load-use cycle.
    rst_i = 1'b0;
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    run_row(mk("cnt0", 10'd0, 10'd0, 5'd0, 0, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b100100));
    run_row(mk("cnt1", 10'd0, 10'd0, 5'd0, 0, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b110011));
    run_row(mk("cnt2", 10'd0, 10'd0, 5'd0, 0, 1, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b011100));
    run_row(mk("cnt3", {5'd7, 5'd1}, 10'd0, 5'd7, 1, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 6'b100111));
    #2 check("stall_cnt_3", cnt3, 32'd3);
    @(negedge clk_i);
    force dut3.r_stall_cnt = 32'hFFFF_FFFF;
    #1 release dut3.r_stall_cnt;
    run_row(vec[5]);
    #2 check("stall_cnt_sat", cnt3, 32'hFFFF_FFFF);
    @(negedge clk_i);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
